// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
package arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;
  localparam int   N_REQ    = 4;
  localparam int   IDX_W    = 2;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT
  } state_t;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_prio_enc4.sv
// Rotated 4-input priority encoder: the first set bit at or after 'start' (wrapping) wins.
module rr_prio_enc4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   pos;

  always_comb begin
    // rot[i] = req[(i + start) mod 4], so rot[0] is the highest-priority client
    dbl = {req, req};
    rot = dbl[start +: N_REQ];
    pos = 2'd0;
    if (rot[0])      pos = 2'd0;
    else if (rot[1]) pos = 2'd1;
    else if (rot[2]) pos = 2'd2;
    else if (rot[3]) pos = 2'd3;
    idx = pos + start;
    any = |req;
  end

endmodule

// File: rtl/rr_arbiter_4req.sv
// Round-robin arbiter for 4 clients: grant held until release or hold-limit timeout,
// with one idle cycle between owners for resource turnaround.
module rr_arbiter_4req
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;

  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               rel_c;
  logic               hold_hit;

  rr_prio_enc4 u_enc (
    .req   (req),
    .start (last_idx_q + 2'd1),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_idx_d = last_idx_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    timeout    = 1'b0;
    rel_c      = done || !req[gnt_idx_q];
    hold_hit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

    case (state_q)
      S_IDLE: begin
        hold_cnt_d = '0;
        if (en && win_any) begin
          state_d   = S_GRANT;
          gnt_d     = idx2onehot(win_idx);
          gnt_idx_d = win_idx;
        end
      end
      S_GRANT: begin
        if (rel_c || hold_hit) begin
          state_d    = S_IDLE;
          gnt_d      = '0;
          hold_cnt_d = '0;
          last_idx_d = gnt_idx_q;
          // A voluntary release in the limit cycle wins over the forced one
          timeout    = hold_hit && !rel_c;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      last_idx_q <= 2'd3;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_idx_q <= last_idx_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = (state_q == S_GRANT);

endmodule

// File: tb/tb_rr_arbiter_4req.sv
// Directed bench for rr_arbiter_4req: reset, fairness, timeout, owner drop, en gating, async reset.
module tb_rr_arbiter_4req;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_arbiter_4req #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_grant(input string tag, input int idx);
    chk({tag, "_gnt"}, int'(gnt), 1 << idx);
    chk({tag, "_idx"}, int'(gnt_idx), idx);
    chk({tag, "_vld"}, int'(gnt_valid), 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, int'(gnt), 0);
    chk({tag, "_vld"}, int'(gnt_valid), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000; done = 1'b0;
    #3;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_idx", int'(gnt_idx), 0);
    chk("rst_vld", int'(gnt_valid), 0);
    chk("rst_tmo", int'(timeout), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic grant, release, dead cycle, next owner
    en = 1'b1; req = 4'b0101;
    step();
    chk_grant("t1_first", 0);
    done = 1'b1; req = 4'b0100;
    step();
    done = 1'b0;
    chk_idle("t1_dead");
    step();
    chk_grant("t1_second", 2);
    done = 1'b1; req = 4'b0000;
    step();
    done = 1'b0;
    chk_idle("t1_end");

    // Owner drops request: release without timeout; last_idx becomes 3
    req = 4'b1000;
    step();
    chk_grant("t4_grant", 3);
    req = 4'b0000;
    step();
    chk_idle("t4_drop");
    chk("t4_tmo", int'(timeout), 0);

    // Fairness from last_idx=3: order 0,1,2,3,0
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_grant($sformatf("t2_g%0d", k), k % 4);
      done = 1'b1;
      step();
      done = 1'b0;
      chk_idle($sformatf("t2_i%0d", k));
    end

    // Hold-limit timeout: exactly 8 grant cycles, pulse on the 8th
    req = 4'b0010;
    step();
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("t3_gnt_c%0d", c), int'(gnt), 4'b0010);
      chk($sformatf("t3_tmo_c%0d", c), int'(timeout), (c == 8) ? 1 : 0);
      step();
    end
    chk_idle("t3_after");
    chk("t3_after_tmo", int'(timeout), 0);
    step();
    chk_grant("t3_regrant", 1);

    // done in the limit cycle: normal release, no timeout pulse
    for (int c = 1; c < 8; c++) step();
    chk("t3b_gnt_c8", int'(gnt), 4'b0010);
    done = 1'b1;
    #1;
    chk("t3b_tmo", int'(timeout), 0);
    step();
    done = 1'b0;
    req = 4'b0000;
    chk_idle("t3b_after");

    // en gating: no grants while en=0; en dropped mid-grant keeps the grant
    en = 1'b0; req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_idle($sformatf("t5_off%0d", c));
    end
    en = 1'b1;
    step();
    chk_grant("t5_grant", 2);
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_grant($sformatf("t5_hold%0d", c), 2);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req = 4'b0000;
    chk_idle("t5_rel");

    // Asynchronous reset mid-grant, then last_idx back to 3
    en = 1'b1; req = 4'b0001;
    step();
    chk_grant("t6_grant", 0);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("t6_async");
    chk("t6_tmo", int'(timeout), 0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1000;
    step();
    chk_grant("t6_after", 3);
    done = 1'b1; req = 4'b0000;
    step();
    done = 1'b0;
    req = 4'b1001;
    step();
    chk_grant("t6_wrap", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog sim_time observed=expired expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
